// File: rtl/switch_bank_pkg.sv
// Shared constants and helpers for the switch_bank register block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package switch_bank_pkg;

  // Register select values on sw_addr
  localparam logic [1:0] REG_VALUE = 2'd0;
  localparam logic [1:0] REG_FLAGS = 2'd1;
  localparam logic [1:0] REG_MASK  = 2'd2;
  localparam logic [1:0] REG_RAW   = 2'd3;

  // Width of a counter that must hold 0..prescale-1; never narrower than 1 bit.
  function automatic int prescale_cnt_width(input int prescale);
    return (prescale > 2) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// One switch bit: 2-flop synchroniser, optional inversion, sample history, debounced level.
// Latency: pin to raw 2 clk; raw to debounced on the STABLE-th equal sample tick.
// Backpressure: none; free-running, samples only when tick is high.
//
// Ports:
//   clk, rst_n : clock, async active-low reset
//   tick       : shared sample strobe from the prescaler (one cycle wide)
//   pin        : asynchronous switch pin
//   raw        : synchronised, polarity-corrected level
//   deb        : debounced level
//   chg        : one-cycle pulse in the cycle deb takes a new value
module switch_debounce #(
  parameter int STABLE = 3,
  parameter int INVERT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic pin,
  output logic raw,
  output logic deb,
  output logic chg
);

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic [STABLE-1:0] hist_q, hist_d;
  logic              deb_q, deb_d;

  always_comb begin
    sync1_d = pin;
    sync2_d = sync1_q;
    raw     = (INVERT != 0) ? ~sync2_q : sync2_q;
    hist_d  = hist_q;
    deb_d   = deb_q;
    chg     = 1'b0;
    if (tick) begin
      hist_d = {hist_q[STABLE-2:0], raw};
      // Judge on the history including this tick's sample so the debounced
      // update lands in the same cycle as the deciding sample.
      if ((hist_d == {STABLE{raw}}) && (raw != deb_q)) begin
        deb_d = raw;
        chg   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= '0;
      deb_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
      deb_q   <= deb_d;
    end
  end

  assign deb = deb_q;

endmodule

// File: rtl/switch_bank.sv
// Debounced switch bank with change flags, maskable irq and a 4-register bus port.
// Latency: reads combinational; writes on the sw_ce&~sw_rw edge; irq 1 clk after flags/mask.
// Backpressure: none; the bus is always ready and reads have no side effects.
//
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   sw_ce, sw_rw        : chip enable from decoder; 1 = read, 0 = write
//   sw_addr             : register select (value, flags, mask, raw)
//   sw_wdata / sw_rdata : write data / read data (high-Z unless reading)
//   sw_input            : asynchronous switch pins
//   sw_irq              : registered |(flags & mask)
module switch_bank #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 50000,
  parameter int STABLE   = 3,
  parameter int INVERT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sw_ce,
  input  logic             sw_rw,
  input  logic [1:0]       sw_addr,
  input  logic [WIDTH-1:0] sw_wdata,
  output logic [WIDTH-1:0] sw_rdata,
  input  logic [WIDTH-1:0] sw_input,
  output logic             sw_irq
);

  import switch_bank_pkg::*;

  localparam int               CNT_W    = prescale_cnt_width(PRESCALE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;
  logic [WIDTH-1:0] raw, deb, chg;
  logic [WIDTH-1:0] flags_q, flags_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             irq_q, irq_d;
  logic             wr_en;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] rd_mux;

  // Prescaler: tick is high for the single cycle the count sits at its top value.
  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    switch_debounce #(
      .STABLE(STABLE),
      .INVERT(INVERT)
    ) u_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick),
      .pin  (sw_input[i]),
      .raw  (raw[i]),
      .deb  (deb[i]),
      .chg  (chg[i])
    );
  end

  // Write decode, flags and irq. A change pulse is OR-ed in after the W1C
  // mask so a new event is never lost to a clear landing in the same cycle.
  always_comb begin
    wr_en  = sw_ce & ~sw_rw;
    mask_d = mask_q;
    w1c    = '0;
    if (wr_en && (sw_addr == REG_MASK)) begin
      mask_d = sw_wdata;
    end
    if (wr_en && (sw_addr == REG_FLAGS)) begin
      w1c = sw_wdata;
    end
    flags_d = (flags_q & ~w1c) | chg;
    irq_d   = |(flags_q & mask_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      flags_q <= '0;
      mask_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
      mask_q  <= mask_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (sw_addr)
      REG_VALUE: rd_mux = deb;
      REG_FLAGS: rd_mux = flags_q;
      REG_MASK:  rd_mux = mask_q;
      REG_RAW:   rd_mux = raw;
    endcase
  end

  // Shared bus: only drive while this block is being read.
  assign sw_rdata = (sw_ce && sw_rw) ? rd_mux : {WIDTH{1'bz}};
  assign sw_irq   = irq_q;

endmodule

// File: tb/tb_switch_bank.sv
// Self-checking bench for switch_bank: scoreboard queue plus behavioural model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_switch_bank;

  localparam int WIDTH    = 8;
  localparam int PRESCALE = 4;
  localparam int STABLE   = 3;
  localparam int INVERT   = 1;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic             sw_ce    = 1'b0;
  logic             sw_rw    = 1'b1;
  logic [1:0]       sw_addr  = 2'd0;
  logic [WIDTH-1:0] sw_wdata = '0;
  logic [WIDTH-1:0] sw_input = 8'hFF;
  // Pulled-up bus: an undriven (high-Z) read shows as all ones.
  tri1  [WIDTH-1:0] sw_rdata;
  logic             sw_irq;

  switch_bank #(
    .WIDTH(WIDTH), .PRESCALE(PRESCALE), .STABLE(STABLE), .INVERT(INVERT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw_ce(sw_ce), .sw_rw(sw_rw), .sw_addr(sw_addr),
    .sw_wdata(sw_wdata), .sw_rdata(sw_rdata), .sw_input(sw_input), .sw_irq(sw_irq)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct {
    string      name;
    bit         is_irq;
    logic [7:0] exp;
  } item_t;

  item_t sb[$];
  logic  chk = 1'b0;
  int    n_chk = 0;
  int    n_pass = 0;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // ---------------- behavioural model ----------------
  // Pins pass through a 2-cycle delay; every PRESCALE-th edge takes a sample;
  // a bit follows its input once the last STABLE samples agree (run length).
  logic [7:0] m_s1, m_s2, m_deb, m_flags, m_mask;
  logic       m_irq;
  int         m_last[WIDTH];
  int         m_run[WIDTH];
  int         edge_cnt;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_deb = '0; m_flags = '0; m_mask = '0; m_irq = 1'b0;
    edge_cnt = 0;
    for (int i = 0; i < WIDTH; i++) begin
      m_last[i] = 0;
      m_run[i]  = STABLE;
    end
  endtask

  task automatic model_step();
    logic [7:0] rawv, chgv, w1c;
    rawv = (INVERT != 0) ? ~m_s2 : m_s2;
    chgv = '0;
    if ((edge_cnt % PRESCALE) == PRESCALE - 1) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (int'(rawv[i]) == m_last[i]) begin
          if (m_run[i] < STABLE) m_run[i]++;
        end else begin
          m_last[i] = int'(rawv[i]);
          m_run[i]  = 1;
        end
        if (m_run[i] >= STABLE && m_last[i] != int'(m_deb[i])) chgv[i] = 1'b1;
      end
    end
    m_irq = |(m_flags & m_mask);
    w1c = (sw_ce && !sw_rw && sw_addr == 2'd1) ? sw_wdata : 8'h00;
    if (sw_ce && !sw_rw && sw_addr == 2'd2) m_mask = sw_wdata;
    m_flags = (m_flags & ~w1c) | chgv;
    m_deb   = m_deb ^ chgv;
    m_s2 = m_s1;
    m_s1 = sw_input;
    edge_cnt++;
  endtask

  function automatic logic [7:0] model_reg(input logic [1:0] a);
    case (a)
      2'd0:    return m_deb;
      2'd1:    return m_flags;
      2'd2:    return m_mask;
      default: return (INVERT != 0) ? ~m_s2 : m_s2;
    endcase
  endfunction

  // Edge index on which the n-th sample of a pin level driven before edge m is taken.
  function automatic int tick_edge(input int m, input int n_ticks);
    int t, n;
    t = m + 1;
    n = 0;
    while (n < n_ticks) begin
      t++;
      if ((t % PRESCALE) == PRESCALE - 1) n++;
    end
    return t;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- monitor ----------------
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (chk) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 8'h01, 8'h00);
        end else begin
          it = sb.pop_front();
          check(it.name, it.is_irq ? {7'b0, sw_irq} : sw_rdata, it.exp);
        end
      end
      check("irq_vs_model", {7'b0, sw_irq}, {7'b0, m_irq});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
    sw_ce = 1'b0;
    sw_rw = 1'b1;
    chk   = 1'b0;
  endtask

  task automatic push(input string nm, input bit is_irq, input logic [7:0] e);
    item_t it;
    it.name = nm; it.is_irq = is_irq; it.exp = e;
    sb.push_back(it);
    chk = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] e, input string nm);
    sw_ce = 1'b1; sw_rw = 1'b1; sw_addr = a;
    push(nm, 1'b0, e);
    cyc();
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    sw_ce = 1'b1; sw_rw = 1'b0; sw_addr = a; sw_wdata = d;
    cyc();
  endtask

  task automatic peek_irq(input logic e, input string nm);
    push(nm, 1'b1, {7'b0, e});
    cyc();
  endtask

  task automatic zchk(input logic ce, input logic rw, input string nm);
    sw_ce = ce; sw_rw = rw; sw_addr = 2'd0; sw_wdata = 8'h5A;
    push(nm, 1'b0, 8'hFF);
    cyc();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int m, t;
    logic [1:0] a;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state with pins held high (logical 0 after inversion)
    rd(2'd0, 8'h00, "rst_value");
    rd(2'd1, 8'h00, "rst_flags");
    rd(2'd2, 8'h00, "rst_mask");
    peek_irq(1'b0, "rst_irq");
    zchk(1'b0, 1'b1, "z_ce0");
    zchk(1'b1, 1'b0, "z_write");
    rd(2'd3, 8'h00, "raw_idle");

    // Bit 3 glitch: 5 clk low is at most 2 samples
    sw_input = 8'hF7;
    repeat (5) cyc();
    sw_input = 8'hFF;
    repeat (30) cyc();
    rd(2'd0, 8'h00, "glitch_value");
    rd(2'd1, 8'h00, "glitch_flags");

    // Bit 0 driven low and held
    sw_input = 8'hFE;
    m = edge_cnt;
    cyc();
    rd(2'd3, 8'h00, "raw_1clk");
    rd(2'd3, 8'h01, "raw_2clk");
    while (edge_cnt < m + 18) cyc();
    rd(2'd0, 8'h01, "deb_bit0");
    rd(2'd1, 8'h01, "flag_bit0");

    // Masked irq on bit 0 returning high
    wr(2'd1, 8'hFF);
    wr(2'd2, 8'h01);
    rd(2'd2, 8'h01, "mask_wr");
    sw_input = 8'hFF;
    m = edge_cnt;
    t = tick_edge(m, STABLE);
    while (edge_cnt < t + 1) cyc();
    peek_irq(1'b0, "irq_lag");
    peek_irq(1'b1, "irq_rise");
    rd(2'd1, 8'h01, "flag0_fall");
    wr(2'd1, 8'h01);
    peek_irq(1'b1, "irq_hold");
    peek_irq(1'b0, "irq_fall");
    rd(2'd1, 8'h00, "flag0_clr");

    // W1C landing on the same edge that sets bit 2's flag
    sw_input = 8'hFB;
    m = edge_cnt;
    t = tick_edge(m, STABLE);
    while (edge_cnt < t - 1) cyc();
    rd(2'd0, 8'h00, "pre_set_value");
    wr(2'd1, 8'h04);
    rd(2'd1, 8'h04, "set_beats_w1c");
    rd(2'd0, 8'h04, "deb_bit2");

    // Reset while bit 5 holds 2 of 3 samples
    sw_input = 8'hDB;
    m = edge_cnt;
    t = tick_edge(m, 2);
    while (edge_cnt < t + 1) cyc();
    rst_n = 1'b0;
    rd(2'd0, 8'h00, "inrst_value");
    rd(2'd1, 8'h00, "inrst_flags");
    rd(2'd2, 8'h00, "inrst_mask");
    peek_irq(1'b0, "inrst_irq");
    rst_n = 1'b1;
    repeat (11) cyc();
    rd(2'd0, 8'h00, "post_rst_2samp");
    rd(2'd0, 8'h24, "post_rst_3samp");
    rd(2'd1, 8'h24, "post_rst_flags");

    // Randomised traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 19) == 0) begin
        int b;
        b = $urandom_range(0, WIDTH - 1);
        sw_input[b] = ~sw_input[b];
      end
      case ($urandom_range(0, 9))
        0: wr(2'd2, 8'($urandom));
        1: wr(2'd1, 8'($urandom));
        2: wr(2'($urandom_range(0, 3)), 8'($urandom));
        3, 4, 5, 6: begin
          a = 2'($urandom_range(0, 3));
          rd(a, model_reg(a), "rand_rd");
        end
        default: cyc();
      endcase
    end

    repeat (3) cyc();
    check("sb_drained", 8'(sb.size()), 8'h00);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/switch_bank.md
# switch_bank

Parametrised, clocked successor to the bussed switch input. It synchronises and debounces WIDTH switch inputs, latches per-bit change flags and raises a maskable interrupt. It exposes four registers on the shared address/data/control bus: value, flags, mask and raw. It sits behind the bus decoder, which drives the chip enable; read data is high-Z whenever the block is not being read.

## Interface
- WIDTH, 8: number of switch inputs and bus data width.
- PRESCALE, 50000: clk cycles between debounce sample ticks; at least 2.
- STABLE, 3: consecutive equal samples required to accept a new level; at least 2.
- INVERT, 1: when 1, raw inputs are inverted to compensate for pull-up wiring.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- sw_ce  in  1  chip enable, active high, from the bus decoder.
- sw_rw  in  1  1 = read, 0 = write.
- sw_addr  in  2  register select.
- sw_wdata  in  WIDTH  write data.
- sw_rdata  out  WIDTH  read data; high-Z unless sw_ce=1 and sw_rw=1.
- sw_input  in  WIDTH  asynchronous switch pins.
- sw_irq  out  1  registered interrupt, active high.

## Operation
- Input path, per bit:
  - Two-flop synchroniser, then optional inversion (INVERT), giving the logical raw value.
  - On each sample tick, the raw value shifts into a STABLE-deep sample history.
  - When all STABLE samples are equal and differ from the debounced value, the debounced bit takes that level and its change flag sets.
- Prescaler: counts 0..PRESCALE-1. The tick is a one-cycle pulse at count PRESCALE-1, after which the counter wraps to 0.
- Register map (address: read / write):
  - 0: debounced value / ignored.
  - 1: change flags / write-1-to-clear.
  - 2: interrupt mask / written with sw_wdata.
  - 3: synchronised raw value (post-inversion) / ignored.
- Read: sw_rdata is a combinational mux of the addressed register while sw_ce & sw_rw, otherwise all Z. Reads have no side effects.
- Write: takes effect on the clk rising edge where sw_ce=1 and sw_rw=0.
- Flag set and W1C clear on the same bit in the same cycle: set wins, so the flag stays 1.
- Interrupt: sw_irq is registered from |(flags & mask) and updates one cycle after flags or mask change.
- Reset values: all of the following are 0 and sw_rdata is Z.
  - synchroniser flops, sample histories, debounced value, flags, mask, prescaler, sw_irq.
  - Consequence: a switch held at logical 1 through reset sets its flag after the first STABLE ticks. This is intended, not spurious.
- Reset asserted mid-debounce: all state clears immediately, with no pending update surviving.

## Timing
- Pin change to raw register (addr 3) visible: 2 clk.
- Pin change to debounced value: 2 clk plus STABLE to STABLE+1 ticks, i.e. at most (STABLE+1)·PRESCALE+2 clk.
- Debounced update and flag set occur in the same cycle.
- Flag set to sw_irq high: 1 clk, if the bit is masked in.
- W1C write to sw_irq low: 1 clk after the write edge, if no other masked flag is set.
- Glitch shorter than one tick period, or any run of fewer than STABLE equal samples: no debounced change and no flag.
- Multiple bits changing on the same tick: each bit updates and flags independently in that cycle.

## Structure
- Package switch_bank_pkg holds:
  - register address constants REG_VALUE=0, REG_FLAGS=1, REG_MASK=2, REG_RAW=3;
  - a function computing the prescaler counter width from PRESCALE.
- Sub-module switch_debounce: one bit, containing the synchroniser, sample history and debounced flop. It takes the shared tick, outputs raw, debounced and a change pulse, and is instantiated WIDTH times via generate.
- Top level holds the prescaler, flags, mask, irq, read mux and write decode.

## Test plan
All scenarios use PRESCALE=4, STABLE=3, INVERT=1 and WIDTH=8 unless stated.
- Reset, then pins held at 8'hFF:
  - value reads 8'h00, flags 8'h00, mask 8'h00, irq 0;
  - sw_rdata is Z with sw_ce=0, and also Z with sw_ce=1, sw_rw=0.
- Bit 0 pin driven low and held:
  - addr 3 reads 8'h01 after 2 clk;
  - addr 0 reads 8'h01 and addr 1 reads 8'h01 within 18 clk.
- Bit 3 pin pulsed low for 5 clk, then released:
  - debounced value and flags remain 8'h00.
- Mask write 8'h01, then bit 0 change:
  - irq rises 1 clk after the flag sets;
  - W1C write of 8'h01 to addr 1 clears the flag, and irq falls 1 clk later.
- W1C to bit 2 issued in the same cycle bit 2's flag sets:
  - flag reads 1 afterwards.
- rst_n asserted while bit 5 has 2 of 3 equal samples:
  - all registers clear asynchronously; after release, the bit needs a full 3 new samples before updating.
